// File: rtl/pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_pkg
// Shared definitions for the LED pulse stretcher and the button-conditioning
// logic that feeds it.
//   - state_e         : stretcher FSM encoding (IDLE / HIGH / GAP)
//   - HIGH_CYCLES_DEF : default on-time of one LED flash, in clock cycles
//   - GAP_CYCLES_DEF  : default off-time between queued flashes, in clock cycles
//   - CNT_W_DEF       : default cycle-counter width (holds the defaults above)
//   - PEND_W_DEF      : default pending-event counter width
// -----------------------------------------------------------------------------
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned HIGH_CYCLES_DEF = 250000;
  localparam int unsigned GAP_CYCLES_DEF  = 250000;
  localparam int unsigned CNT_W_DEF       = 20;
  localparam int unsigned PEND_W_DEF      = 3;

endpackage

// File: rtl/pulse_stretcher_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Turns a level input into a one-cycle strobe on each 0->1 transition.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (clears the history register)
//   sig_i  : level input, synchronous to clk
//   rise_o : combinational strobe, high in the cycle where sig_i is 1 and
//            was 0 in the previous cycle
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Stretches single-cycle events into LED flashes of HIGH_CYCLES on-time
// followed by GAP_CYCLES off-time. Events arriving while a flash is running
// are queued in a saturating pending counter and shown as separate flashes.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset, clears all state
//   pulse_in  : event input; each rising edge is one event
//   led_out   : stretched pulse (registered)
//   busy      : 1 whenever the FSM is not IDLE (registered)
//   pending   : queued events not yet displayed (registered)
//   overflow  : one-cycle strobe when an event is dropped (registered)
//   dbg_state : current FSM state, for observation only
// Handshake: none; pulse_in is sampled every cycle, outputs are plain levels.
// -----------------------------------------------------------------------------
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = HIGH_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned PEND_W      = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic ev;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst_n  (rst),
    .sig_i  (pulse_in),
    .rise_o (ev)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end
      end

      ST_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // Queue the event; a full queue drops it and flags the drop.
        if (ev) begin
          if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
          end else begin
            pend_d = pend_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            // Consume one queued event; an event arriving in the same cycle
            // replaces it, so the count is unchanged.
            state_d = ST_HIGH;
            if (!ev) begin
              pend_d = pend_q - 1'b1;
            end
          end else if (ev) begin
            // Fresh event exactly at the end of the gap restarts directly.
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (ev) begin
            if (pend_q == PEND_MAX) begin
              ovf_d = 1'b1;
            end else begin
              pend_d = pend_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    led_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  assign led_out   = led_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule
